// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - decode-side integer register file with in-order busy scoreboard
//
// Purpose:
//   32 x XLEN register file (x0 hardwired to zero, not stored) with one busy bit per
//   register. Decode issues set the destination busy bit; writeback commits clear it.
//   Supplies two combinational operand reads, per-source busy flags and a decode stall.
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a writeback in the current cycle is forwarded to
//   the operand reads and masks the written register's busy bit, so a dependent can
//   issue in the producer's WB cycle. When undefined, reads come from storage only.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   DE_SR1/2, DE_SR1/2_USE     decode source indices and use qualifiers
//   DE_ISSUE_V/DR/WEN          decode issue request, destination and write flag
//   WB_REG_WEN/WB_DR/WB_Data   writeback register write
//   WB_FLUSH                   writeback redirect, squashes all in-flight busy state
//   DE_SR1/2_DATA, _BUSY       operand values and pending-write flags
//   DE_STALL, DE_ISSUED        decode hold and issue-accepted strobes

module decode_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      DE_SR1,
  input  logic [4:0]      DE_SR2,
  input  logic            DE_SR1_USE,
  input  logic            DE_SR2_USE,
  input  logic            DE_ISSUE_V,
  input  logic [4:0]      DE_ISSUE_DR,
  input  logic            DE_ISSUE_WEN,
  input  logic            WB_REG_WEN,
  input  logic [4:0]      WB_DR,
  input  logic [XLEN-1:0] WB_Data,
  input  logic            WB_FLUSH,
  output logic [XLEN-1:0] DE_SR1_DATA,
  output logic [XLEN-1:0] DE_SR2_DATA,
  output logic            DE_SR1_BUSY,
  output logic            DE_SR2_BUSY,
  output logic            DE_STALL,
  output logic            DE_ISSUED
);

  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic [NREG-1:0] r_busy;

  logic [NREG-1:0] w_busy_eff;
  logic [XLEN-1:0] w_sr1_data;
  logic [XLEN-1:0] w_sr2_data;
  logic            w_raw;
  logic            w_waw;
  logic            w_stall;
  logic            w_issued;
  logic            w_issue_set;
  logic            w_wb_commit;

  assign w_wb_commit = WB_REG_WEN && (WB_DR != 5'd0);

  // Busy view seen by decode; with bypass the register committing this cycle is
  // already available, so it no longer blocks.
  always_comb begin
    w_busy_eff = r_busy;
    w_busy_eff[0] = 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (WB_REG_WEN) w_busy_eff[WB_DR] = 1'b0;
`endif
  end

  always_comb begin
    w_sr1_data = '0;
    w_sr2_data = '0;
    for (int i = 1; i < NREG; i++) begin
      if (DE_SR1 == 5'(i)) w_sr1_data = r_regs[i];
      if (DE_SR2 == 5'(i)) w_sr2_data = r_regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wb_commit && (WB_DR == DE_SR1)) w_sr1_data = WB_Data;
    if (w_wb_commit && (WB_DR == DE_SR2)) w_sr2_data = WB_Data;
`endif
  end

  assign w_raw       = (DE_SR1_USE && w_busy_eff[DE_SR1]) || (DE_SR2_USE && w_busy_eff[DE_SR2]);
  assign w_waw       = DE_ISSUE_WEN && w_busy_eff[DE_ISSUE_DR];
  assign w_stall     = DE_ISSUE_V && !WB_FLUSH && (w_raw || w_waw);
  assign w_issued    = DE_ISSUE_V && !w_stall && !WB_FLUSH;
  assign w_issue_set = w_issued && DE_ISSUE_WEN && (DE_ISSUE_DR != 5'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy <= '0;
      for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (WB_REG_WEN && (WB_DR == 5'(i))) r_regs[i] <= WB_Data;
      end
      // Flush drops every in-flight write; the same-cycle WB commit belongs to the
      // redirecting instruction, so its data write above still happens.
      if (WB_FLUSH) begin
        r_busy <= '0;
      end else begin
        if (w_wb_commit) r_busy[WB_DR] <= 1'b0;
        // Issued instruction is younger than the one in WB: its set overrides the clear.
        if (w_issue_set) r_busy[DE_ISSUE_DR] <= 1'b1;
      end
    end
  end

  assign DE_SR1_DATA = w_sr1_data;
  assign DE_SR2_DATA = w_sr2_data;
  assign DE_SR1_BUSY = w_busy_eff[DE_SR1];
  assign DE_SR2_BUSY = w_busy_eff[DE_SR2];
  assign DE_STALL    = w_stall;
  assign DE_ISSUED   = w_issued;

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - self-checking bench for decode_regfile
module tb_decode_regfile;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [4:0]  DE_SR1, DE_SR2, DE_ISSUE_DR, WB_DR;
  logic        DE_SR1_USE, DE_SR2_USE, DE_ISSUE_V, DE_ISSUE_WEN, WB_REG_WEN, WB_FLUSH;
  logic [63:0] WB_Data;
  logic [63:0] DE_SR1_DATA, DE_SR2_DATA;
  logic        DE_SR1_BUSY, DE_SR2_BUSY, DE_STALL, DE_ISSUED;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  decode_regfile dut (
    .CLK(CLK), .RESET(RESET),
    .DE_SR1(DE_SR1), .DE_SR2(DE_SR2), .DE_SR1_USE(DE_SR1_USE), .DE_SR2_USE(DE_SR2_USE),
    .DE_ISSUE_V(DE_ISSUE_V), .DE_ISSUE_DR(DE_ISSUE_DR), .DE_ISSUE_WEN(DE_ISSUE_WEN),
    .WB_REG_WEN(WB_REG_WEN), .WB_DR(WB_DR), .WB_Data(WB_Data), .WB_FLUSH(WB_FLUSH),
    .DE_SR1_DATA(DE_SR1_DATA), .DE_SR2_DATA(DE_SR2_DATA),
    .DE_SR1_BUSY(DE_SR1_BUSY), .DE_SR2_BUSY(DE_SR2_BUSY),
    .DE_STALL(DE_STALL), .DE_ISSUED(DE_ISSUED)
  );

  always #5 CLK = ~CLK;

  // Reference model: architectural register values and pending-write set.
  logic [63:0] m_regs [32];
  bit          m_busy [32];
  bit          m_iss;

  function automatic bit m_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (BYP && WB_REG_WEN && WB_DR == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic logic [63:0] m_value(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (BYP && WB_REG_WEN && WB_DR == r) return WB_Data;
    return m_regs[r];
  endfunction

  function automatic bit m_stall();
    bit hazard;
    hazard = (DE_SR1_USE && m_pending(DE_SR1)) || (DE_SR2_USE && m_pending(DE_SR2)) ||
             (DE_ISSUE_WEN && m_pending(DE_ISSUE_DR));
    return DE_ISSUE_V && !WB_FLUSH && hazard;
  endfunction

  function automatic bit m_issue();
    return DE_ISSUE_V && !WB_FLUSH && !m_stall();
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 64'd0; m_busy[i] = 1'b0; end
    end else begin
      m_iss = m_issue();
      if (WB_REG_WEN && WB_DR != 5'd0) begin
        m_regs[WB_DR] = WB_Data;
        m_busy[WB_DR] = 1'b0;
      end
      if (WB_FLUSH) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (m_iss && DE_ISSUE_WEN && DE_ISSUE_DR != 5'd0) begin
        m_busy[DE_ISSUE_DR] = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_sr1_data", DE_SR1_DATA, m_value(DE_SR1));
      chk("m_sr2_data", DE_SR2_DATA, m_value(DE_SR2));
      chk("m_sr1_busy", {63'd0, DE_SR1_BUSY}, {63'd0, m_pending(DE_SR1)});
      chk("m_sr2_busy", {63'd0, DE_SR2_BUSY}, {63'd0, m_pending(DE_SR2)});
      chk("m_stall", {63'd0, DE_STALL}, {63'd0, m_stall()});
      chk("m_issued", {63'd0, DE_ISSUED}, {63'd0, m_issue()});
    end
  end

  task automatic idle();
    DE_SR1 = 0; DE_SR2 = 0; DE_SR1_USE = 0; DE_SR2_USE = 0;
    DE_ISSUE_V = 0; DE_ISSUE_DR = 0; DE_ISSUE_WEN = 0;
    WB_REG_WEN = 0; WB_DR = 0; WB_Data = 0; WB_FLUSH = 0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle();
  endtask

  task automatic issue(input logic [4:0] dr);
    DE_ISSUE_V = 1; DE_ISSUE_WEN = 1; DE_ISSUE_DR = dr;
  endtask

  task automatic wb(input logic [4:0] dr, input logic [63:0] d);
    WB_REG_WEN = 1; WB_DR = dr; WB_Data = d;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    #1 RESET = 1'b1;
    chk_en = 1'b1;
    #1;
    // Reset: outputs clear, issue passes straight through.
    issue(5'd3); DE_SR1 = 5'd5; DE_SR1_USE = 1;
    #1;
    chk("rst_data", DE_SR1_DATA, 64'd0);
    chk("rst_busy", {63'd0, DE_SR1_BUSY}, 64'd0);
    chk("rst_stall", {63'd0, DE_STALL}, 64'd0);
    chk("rst_issued", {63'd0, DE_ISSUED}, 64'd1);
    @(posedge CLK); #1 RESET = 1'b0; idle();

    // Mid-run reset with x5 busy and holding 0x1234.
    nxt(); wb(5'd5, 64'h1234); issue(5'd5);
    #1 chk("x5_issue", {63'd0, DE_ISSUED}, 64'd1);
    nxt(); DE_SR1 = 5'd5; DE_SR1_USE = 1;
    #1;
    chk("x5_busy", {63'd0, DE_SR1_BUSY}, 64'd1);
    chk("x5_data", DE_SR1_DATA, 64'h1234);
    #1 RESET = 1'b1;
    #1;
    chk("midrst_data", DE_SR1_DATA, 64'd0);
    chk("midrst_busy", {63'd0, DE_SR1_BUSY}, 64'd0);

    // x0 behaviour.
    nxt(); wb(5'd0, 64'hDEAD);
    nxt(); DE_SR1 = 5'd0; issue(5'd0);
    #1;
    chk("x0_data", DE_SR1_DATA, 64'd0);
    chk("x0_stall", {63'd0, DE_STALL}, 64'd0);
    chk("x0_issued", {63'd0, DE_ISSUED}, 64'd1);
    nxt(); DE_SR1 = 5'd0; DE_SR1_USE = 1; issue(5'd0);
    #1;
    chk("x0_busy", {63'd0, DE_SR1_BUSY}, 64'd0);
    chk("x0_waw", {63'd0, DE_STALL}, 64'd0);

    // RAW on x7.
    nxt(); issue(5'd7);
    nxt(); DE_ISSUE_V = 1; DE_SR1 = 5'd7; DE_SR1_USE = 1;
    #1;
    chk("raw_stall", {63'd0, DE_STALL}, 64'd1);
    chk("raw_noissue", {63'd0, DE_ISSUED}, 64'd0);
    nxt(); DE_ISSUE_V = 1; DE_SR1 = 5'd7; DE_SR1_USE = 1; wb(5'd7, 64'hAA);
    #1;
    chk("raw_wb_stall", {63'd0, DE_STALL}, BYP ? 64'd0 : 64'd1);
    chk("raw_wb_data", DE_SR1_DATA, BYP ? 64'hAA : 64'h0);
    nxt(); DE_ISSUE_V = 1; DE_SR1 = 5'd7; DE_SR1_USE = 1;
    #1;
    chk("raw_after_stall", {63'd0, DE_STALL}, 64'd0);
    chk("raw_after_data", DE_SR1_DATA, 64'hAA);

    // Same-cycle set and clear on x9.
    nxt(); wb(5'd9, 64'h99); issue(5'd9);
    #1 chk("sc_issued", {63'd0, DE_ISSUED}, 64'd1);
    nxt(); DE_SR1 = 5'd9; DE_SR2 = 5'd9;
    #1;
    chk("sc_busy", {63'd0, DE_SR1_BUSY}, 64'd1);
    chk("sc_data", DE_SR2_DATA, 64'h99);

    // Flush with concurrent WB write and issue.
    nxt(); issue(5'd3);
    nxt(); issue(5'd4);
    nxt(); issue(5'd6);
    nxt(); WB_FLUSH = 1; wb(5'd3, 64'h55); issue(5'd8);
    #1;
    chk("fl_issued", {63'd0, DE_ISSUED}, 64'd0);
    chk("fl_stall", {63'd0, DE_STALL}, 64'd0);
    nxt(); DE_SR1 = 5'd3; DE_SR2 = 5'd8;
    #1;
    chk("fl_b3", {63'd0, DE_SR1_BUSY}, 64'd0);
    chk("fl_x3", DE_SR1_DATA, 64'h55);
    chk("fl_b8", {63'd0, DE_SR2_BUSY}, 64'd0);
    DE_SR1 = 5'd4; DE_SR2 = 5'd6;
    #1;
    chk("fl_b4", {63'd0, DE_SR1_BUSY}, 64'd0);
    chk("fl_b6", {63'd0, DE_SR2_BUSY}, 64'd0);

    // WAW on x12.
    nxt(); issue(5'd12);
    nxt(); issue(5'd12);
    #1;
    chk("waw_stall", {63'd0, DE_STALL}, 64'd1);
    chk("waw_noissue", {63'd0, DE_ISSUED}, 64'd0);
    nxt(); issue(5'd12); wb(5'd12, 64'hC);
    #1;
    chk("waw_wb_stall", {63'd0, DE_STALL}, BYP ? 64'd0 : 64'd1);
    chk("waw_wb_issued", {63'd0, DE_ISSUED}, BYP ? 64'd1 : 64'd0);
    nxt(); DE_SR1 = 5'd12;
    #1;
    chk("waw_busy_after", {63'd0, DE_SR1_BUSY}, BYP ? 64'd1 : 64'd0);
    chk("waw_data_after", DE_SR1_DATA, 64'hC);

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      DE_SR1 = rnd_reg(); DE_SR2 = rnd_reg();
      DE_SR1_USE = 1'($urandom_range(0, 1));
      DE_SR2_USE = 1'($urandom_range(0, 1));
      DE_ISSUE_V = ($urandom_range(0, 9) < 7);
      DE_ISSUE_WEN = ($urandom_range(0, 3) != 0);
      DE_ISSUE_DR = rnd_reg();
      WB_REG_WEN = 1'($urandom_range(0, 1));
      WB_DR = rnd_reg();
      for (int t = 0; t < 6 && !m_busy[WB_DR]; t++) WB_DR = rnd_reg();
      WB_Data = {$urandom, $urandom};
      WB_FLUSH = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 RESET = 1'b1;
      end
    end

    nxt();
    @(posedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Decode-side 32 x 64-bit integer register file with an in-order scoreboard. It is the receiving end of the writeback stage's register-write and redirect signals. It also supplies two combinational source-operand reads, per-source busy flags and a decode stall to the decode stage. Busy bits are set when decode issues a destination register and cleared when writeback commits it.

## Interface
Parameters:
- XLEN, 64, register width.
- NREG, 32, register count; indices are 5 bits.

Ports:
- CLK  input  1  rising-edge clock; the block's only clock.
- RESET  input  1  asynchronous, active-high reset.
- DE_SR1  input  5  source register 1 index.
- DE_SR2  input  5  source register 2 index.
- DE_SR1_USE  input  1  decode instruction reads SR1.
- DE_SR2_USE  input  1  decode instruction reads SR2.
- DE_ISSUE_V  input  1  decode instruction is valid and requests issue.
- DE_ISSUE_DR  input  5  destination register of the issuing instruction.
- DE_ISSUE_WEN  input  1  issuing instruction writes a register.
- WB_REG_WEN  input  1  writeback register write enable (already qualified by WB valid).
- WB_DR  input  5  writeback destination index.
- WB_Data  input  64  writeback result.
- WB_FLUSH  input  1  writeback redirect (valid PC-mux select); squashes all younger in-flight instructions.
- DE_SR1_DATA  output  64  SR1 operand.
- DE_SR2_DATA  output  64  SR2 operand.
- DE_SR1_BUSY  output  1  SR1 has a pending write.
- DE_SR2_BUSY  output  1  SR2 has a pending write.
- DE_STALL  output  1  decode must hold its instruction this cycle.
- DE_ISSUED  output  1  issue accepted this cycle.

## Operation
- Storage: regs[1..31] are XLEN flops; x0 is not stored.
  - Reads of x0 return 0.
  - Writes with WB_DR==0 are discarded.
  - busy[0] is constant 0.
- Write: at each rising CLK with WB_REG_WEN=1 and WB_DR!=0, regs[WB_DR] <= WB_Data and busy[WB_DR] is cleared.
- Stall: DE_STALL = DE_ISSUE_V & ~WB_FLUSH & (RAW | WAW).
  - RAW = (DE_SR1_USE & DE_SR1_BUSY) | (DE_SR2_USE & DE_SR2_BUSY).
  - WAW = DE_ISSUE_WEN & busy_eff[DE_ISSUE_DR].
- Issue: DE_ISSUED = DE_ISSUE_V & ~DE_STALL & ~WB_FLUSH. If DE_ISSUED & DE_ISSUE_WEN & DE_ISSUE_DR!=0, busy[DE_ISSUE_DR] is set at the edge.
- Flush: WB_FLUSH=1 clears all busy bits at the edge.
  - Issue is suppressed that cycle.
  - A WB write in the same cycle still commits, because it belongs to the redirecting instruction.
  - Rationale: the pipeline is in-order, so every instruction older than the redirecting one has already written back.
- Simultaneous events on the same register in one cycle:
  - Issue-set and WB-clear: set wins (the issuing instruction is younger).
  - Flush and issue: flush wins.
  - WAW stalls guarantee at most one outstanding write per register.
- busy_eff[r]: equals busy[r] & ~(WB_REG_WEN & WB_DR==r) when bypass is compiled in; equals busy[r] otherwise. DE_SRx_BUSY = busy_eff[DE_SRx].

## Timing
- Reads and all flags are combinational from current state plus WB_* inputs; there is no read latency.
- Register writes and busy updates take effect at the rising CLK edge.
- Reset (asynchronous, effective immediately): all regs 0, all busy 0. Consequently DE_SRx_DATA=0, DE_SRx_BUSY=0, DE_STALL=0 and DE_ISSUED=DE_ISSUE_V until the first edge after release.
- Reset asserted mid-operation discards pending busy state; writes in that cycle are lost.
- Issue-to-dependent-read: with bypass, a dependent instruction issues in the same cycle the producer is in WB. Without bypass, it issues one cycle later.

## Configuration
- REGFILE_BYPASS_EN defined:
  - DE_SRx_DATA = WB_Data when WB_REG_WEN & WB_DR==DE_SRx & DE_SRx!=0; otherwise regs[DE_SRx].
  - busy_eff masks the register being written this cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored regs only.
  - busy_eff = busy, so dependents stall through the WB cycle.

## Test plan
- Reset: assert RESET mid-run with busy[5]=1 and x5=0x1234 -> DE_SR1_DATA=0 and DE_SR1_BUSY=0 immediately for DE_SR1=5.
- x0: WB write DR=0 with 0xDEAD, then read SR1=0 -> data 0; issue DR=0 -> busy[0] stays 0 and no WAW stall.
- RAW: issue DR=7 at cycle 0; decode with SR1=7, USE=1 -> DE_STALL=1 until WB writes x7=0xAA.
  - Bypass build: stall drops in the WB cycle and DE_SR1_DATA=0xAA.
  - Non-bypass build: stall drops the cycle after, with 0xAA from storage.
- Same-cycle set/clear: WB writes x9 while decode issues DR=9 -> busy[9]=1 after the edge and x9 holds the WB value.
- Flush: busy on x3, x4 and x6; WB_FLUSH with a WB write x3=0x55 and a concurrent issue DR=8 -> all busy 0 after the edge, x3=0x55, busy[8]=0, DE_ISSUED=0.
- WAW: busy[12]=1; issue DR=12 with no source use -> DE_STALL=1 and DE_ISSUED=0 until x12 writes back.
